// File: rtl/etapa_if_pkg.sv
// etapa_if_pkg: fetch-stage state encoding, IF/ID layout and opcode values shared with the control unit.
package etapa_if_pkg;
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} if_state_t;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;
    function automatic logic [5:0] get_opcode(input logic [31:0] inst);
        return inst[OP_HI:OP_LO];
    endfunction
endpackage

// File: rtl/etapa_if_registro.sv
// registro_if_id: 65-bit IF/ID pipeline register with load enable and synchronous flush to a NOP bubble.
module registro_if_id
    import etapa_if_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);
    if_id_t reg_q, reg_d;

    always_comb reg_d = flush ? '{inst: NOP_INST, pc4: 32'h0, valid: 1'b0} : en ? d : reg_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) reg_q <= '0;
        else     reg_q <= reg_d;

    assign q = reg_q;
endmodule

// File: rtl/etapa_if.sv
// etapa_if: instruction-fetch stage; PC, valid/ready fetch FSM with skid buffer and drain of killed requests.
module etapa_if
    import etapa_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode
);
    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d, skid_q, skid_d;
    logic        ld, flush;
    if_id_t      ld_val, if_id;

    assign imem_req  = !rst && state_q != HOLD;
    assign imem_addr = state_q == DRAIN ? req_addr_q : pc_q;
    // In HOLD the PC already points past the buffered word, so it is that word's pc4.
    assign ld_val = state_q == HOLD ? '{inst: skid_q, pc4: pc_q, valid: 1'b1}
                                    : '{inst: imem_rdata, pc4: pc_q + PC_INC, valid: 1'b1};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        skid_d     = skid_q;
        ld         = 1'b0;
        flush      = 1'b0;
        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    pc_d       = branch_target;
                    flush      = 1'b1;
                    req_addr_d = imem_ready ? req_addr_q : pc_q;
                    state_d    = imem_ready ? FETCH : DRAIN;
                end else if (imem_ready) begin
                    pc_d    = pc_q + PC_INC;
                    ld      = !stall;
                    skid_d  = stall ? imem_rdata : skid_q;
                    state_d = stall ? HOLD : FETCH;
                end else begin
                    flush = !stall;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    flush   = 1'b1;
                    skid_d  = NOP_INST;
                    state_d = FETCH;
                end else if (!stall) begin
                    ld      = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // The killed request stays on the bus until accepted; its data never reaches IF/ID.
                flush   = 1'b1;
                pc_d    = branch_taken ? branch_target : pc_q;
                state_d = imem_ready ? FETCH : DRAIN;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= 32'h0;
            skid_q     <= NOP_INST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            skid_q     <= skid_d;
        end

    registro_if_id u_if_id (
        .clk   (clk),
        .rst   (rst),
        .en    (ld),
        .flush (flush),
        .d     (ld_val),
        .q     (if_id)
    );

    assign if_id_inst  = if_id.inst;
    assign if_id_pc4   = if_id.pc4;
    assign if_id_valid = if_id.valid;
    assign opcode      = get_opcode(if_id.inst);
endmodule

// File: tb/tb_etapa_if.sv
// tb_etapa_if: directed test-plan steps then random traffic, checked against a transaction-level fetch model.
module tb_etapa_if;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        scr = 1'b0;
    logic        imem_req, if_id_valid, w_imem_req, w_if_id_valid;
    logic [31:0] imem_addr, imem_rdata, if_id_inst, if_id_pc4;
    logic [31:0] w_imem_addr, w_imem_rdata, w_if_id_inst, w_if_id_pc4;
    logic [5:0]  opcode, w_opcode;
    int          checks = 0, errors = 0;

    // Model: a fetch PC, an optional parked word, an optional killed request still on the bus.
    logic [31:0] m_pc, m_buf, m_kill_addr, m_inst, m_pc4;
    logic        m_has_buf, m_kill, m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic s);
        return (a + 32'h100) ^ (s ? {a[9:4], 26'h0} : 32'h0);
    endfunction

    assign imem_rdata   = mem_word(imem_addr, scr);
    assign w_imem_rdata = mem_word(w_imem_addr, scr);

    always #5 clk = ~clk;

    etapa_if dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .opcode(opcode)
    );

    etapa_if #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready), .imem_rdata(w_imem_rdata),
        .if_id_inst(w_if_id_inst), .if_id_pc4(w_if_id_pc4), .if_id_valid(w_if_id_valid), .opcode(w_opcode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_buf = 32'h0; m_kill_addr = 32'h0;
        m_has_buf = 1'b0; m_kill = 1'b0;
        m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic bubble();
        m_inst = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [31:0] t, input logic r);
        logic [31:0] w;
        if (m_kill) begin
            bubble();
            if (b) m_pc = t;
            if (r) m_kill = 1'b0;
        end else if (m_has_buf) begin
            if (b) begin
                m_pc = t; m_has_buf = 1'b0; bubble();
            end else if (!s) begin
                m_inst = m_buf; m_pc4 = m_pc; m_valid = 1'b1; m_has_buf = 1'b0;
            end
        end else if (b) begin
            bubble();
            if (!r) begin
                m_kill = 1'b1; m_kill_addr = m_pc;
            end
            m_pc = t;
        end else if (r) begin
            w = mem_word(m_pc, scr);
            if (s) begin
                m_buf = w; m_has_buf = 1'b1;
            end else begin
                m_inst = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            bubble();
        end
    endtask

    // Entered at posedge+1; leaves at posedge+1 of the next cycle.
    task automatic cyc(input logic s, input logic b, input logic [31:0] t, input logic r);
        stall = s; branch_taken = b; branch_target = t; imem_ready = r;
        #2;
        chk("imem_req", imem_req, !m_has_buf);
        if (!m_has_buf) chk("imem_addr", imem_addr, m_kill ? m_kill_addr : m_pc);
        @(posedge clk);
        model_step(s, b, t, r);
        #1;
        chk("if_id_valid", if_id_valid, m_valid);
        chk("if_id_inst", if_id_inst, m_inst);
        chk("opcode", opcode, m_inst[31:26]);
        if (m_valid) chk("if_id_pc4", if_id_pc4, m_pc4);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_req", imem_req, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst", if_id_inst, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk("rst_valid", if_id_valid, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        #2;
        chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1);
        chk("tp1_inst0", if_id_inst, 32'h100);
        chk("tp1_pc4_0", if_id_pc4, 32'h4);
        chk("wrap_addr1", w_imem_addr, 32'h0);
        chk("wrap_pc4", w_if_id_pc4, 32'h0);
        chk("wrap_inst", w_if_id_inst, 32'h0000_00FC);
        cyc(0, 0, 0, 1);
        chk("tp1_inst1", if_id_inst, 32'h104);
        chk("tp1_pc4_1", if_id_pc4, 32'h8);

        do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("tp2_wait_valid", if_id_valid, 1'b0);
        cyc(0, 0, 0, 1);
        chk("tp2_inst", if_id_inst, 32'h100);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("tp3_hold_inst", if_id_inst, 32'h104);
        cyc(0, 0, 0, 1);
        chk("tp3_inst", if_id_inst, 32'h108);
        chk("tp3_pc4", if_id_pc4, 32'hC);
        #1;
        chk("tp3_next_addr", imem_addr, 32'hC);

        cyc(1, 0, 0, 1);
        cyc(1, 1, 32'h40, 1);
        chk("tp4_flush_inst", if_id_inst, 32'h0);
        chk("tp4_flush_valid", if_id_valid, 1'b0);
        cyc(0, 0, 0, 1);
        chk("tp4_target_inst", if_id_inst, 32'h140);

        cyc(0, 1, 32'h10, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h80, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("tp5_drop_valid", if_id_valid, 1'b0);
        #1;
        chk("tp5_next_addr", imem_addr, 32'h80);
        cyc(0, 0, 0, 1);
        chk("tp5_inst", if_id_inst, 32'h180);

        cyc(0, 1, 32'h200, 0);
        cyc(0, 0, 0, 0);
        imem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("tp6_req", imem_req, 1'b0);
        chk("tp6_inst", if_id_inst, 32'h0);
        chk("tp6_pc4", if_id_pc4, 32'h0);
        chk("tp6_valid", if_id_valid, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 1);
        chk("tp6_after_inst", if_id_inst, 32'h100);

        scr = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            else cyc($urandom_range(3) == 0, $urandom_range(9) == 0,
                     {$urandom_range(1023), 2'b00}, $urandom_range(9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
